multiplexer4_1: RTL and testbench
=================================

MULTIPLEXER4_1 -- requirements
Module: multiplexer4_1

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each data channel and of the outputs.
REQ-002 clk  input  1  single clock; rising-edge active; used only by the registered output path.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i  input  4*WIDTH  four packed data channels; channel n occupies bits [n*WIDTH +: WIDTH].
REQ-005 s  input  2  channel select, unsigned binary: 00->ch0, 01->ch1, 10->ch2, 11->ch3.
REQ-006 y  output  WIDTH  combinational selected channel.
REQ-007 y_q  output  WIDTH  registered copy of y.
REQ-008 sel_oh  output  4  combinational one-hot decode of s (bit n high when s==n).

Function
REQ-009 y SHALL equal channel s of i at all times, with zero clock latency, in the same delta as any change on i or s.
REQ-010 y SHALL NOT depend on clk or rst_n; it SHALL be valid during reset.
REQ-011 y_q SHALL capture y on every rising clk edge while rst_n is high, giving exactly one cycle of latency.
REQ-012 sel_oh SHALL have exactly one bit set for every legal s value; sel_oh[s] = 1.
REQ-013 If s contains X/Z, y SHALL be X (simulation) and no channel is preferred; synthesis is don't-care-free (full case).
REQ-014 Only the selected channel SHALL affect y; toggling any unselected channel SHALL leave y and y_q unchanged.
REQ-015 Simultaneous change of i and s SHALL produce y for the new s and new i.
REQ-016 The design SHALL be free of latches; every select value SHALL be decoded explicitly.

Reset
REQ-017 While rst_n is low, y_q SHALL be 0 (all WIDTH bits), immediately and independent of clk.
REQ-018 Asserting rst_n mid-operation SHALL clear y_q asynchronously; y and sel_oh continue to follow inputs.
REQ-019 After rst_n deasserts, the first rising clk edge SHALL load y into y_q.

Structure
REQ-020 A shared package multiplexer4_1_pkg SHALL hold the select encodings SEL_CH0..SEL_CH3 (2'b00..2'b11) and the channel count constant NUM_CH = 4.
REQ-021 The combinational path SHALL be built as a tree of three instances of one sub-module mux2_1 (WIDTH-parameterized 2:1 mux): s[0] selects at the first level, s[1] at the second.
REQ-022 The y_q register SHALL be a single always block in the top module with async active-low reset.

Verification
REQ-023 Reset: rst_n=0, i=4'b1111, s=2'b10 -> y=1, y_q=0, sel_oh=4'b0100; release rst_n, one clk edge -> y_q=1.
REQ-024 Walking one: for k=0..3 set i=4'b0001<<k, sweep s=00,01,10,11 -> y=1 only when s==k, else 0; y_q follows one cycle later.
REQ-025 Isolation: s=2'b01, i toggles among 4'b1101/4'b0000/4'b0010 -> y=0,0,1 matching bit 1 only.
REQ-026 Reset mid-operation: i=4'b1000, s=2'b11, y_q=1, pull rst_n low between edges -> y_q=0 at once, y stays 1.
REQ-027 Width: WIDTH=8, i={8'hDD,8'hCC,8'hBB,8'hAA}, s=00..11 -> y=AA,BB,CC,DD.
REQ-028 Exhaustive WIDTH=1: all 64 (i,s) combinations -> y==i[s] and sel_oh==(4'b0001<<s).

Source files
------------

// File: rtl/multiplexer4_1_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : multiplexer4_1_pkg
// Purpose : Shared constants for the 4:1 multiplexer. Holds the select
//           encodings, the channel count and a one-hot decode helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
package multiplexer4_1_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;
  localparam logic [1:0] SEL_CH3 = 2'b11;

  // Each legal select value gets its own case item, so no value falls
  // through to an implicit default. An X/Z select yields all zeros here.
  function automatic logic [NUM_CH-1:0] sel_decode(input logic [1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    case (sel)
      SEL_CH0: oh = 4'b0001;
      SEL_CH1: oh = 4'b0010;
      SEL_CH2: oh = 4'b0100;
      SEL_CH3: oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multiplexer4_1_mux2_1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mux2_1
// Purpose : WIDTH-bit 2:1 combinational multiplexer, the leaf cell of the
//           4:1 tree.
// Ports   : a   - input  [WIDTH-1:0]  selected when sel == 0
//           b   - input  [WIDTH-1:0]  selected when sel == 1
//           sel - input               select
//           y   - output [WIDTH-1:0]  selected data
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module mux2_1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // A case statement is used rather than ?: so that an unknown select
  // drives X in simulation instead of merging matching bits of a and b.
  // Both 1-bit values are decoded, so the default is unreachable in
  // hardware.
  always_comb begin
    y = a;
    case (sel)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = 'x;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multiplexer4_1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : multiplexer4_1
// Purpose : WIDTH-bit 4:1 multiplexer with a combinational output, a
//           registered copy and a one-hot select decode.
// Ports   : clk    - input                clock for the y_q register
//           rst_n  - input                async active-low reset of y_q
//           i      - input  [4*WIDTH-1:0] channel n at [n*WIDTH +: WIDTH]
//           s      - input  [1:0]         channel select
//           y      - output [WIDTH-1:0]   combinational selected channel
//           y_q    - output [WIDTH-1:0]   y delayed by one clock
//           sel_oh - output [3:0]         one-hot decode of s
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module multiplexer4_1
  import multiplexer4_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] i,
  input  logic [1:0]              s,
  output logic [WIDTH-1:0]        y,
  output logic [WIDTH-1:0]        y_q,
  output logic [NUM_CH-1:0]       sel_oh
);

  logic [WIDTH-1:0] ch [NUM_CH];
  logic [WIDTH-1:0] lo_pair;
  logic [WIDTH-1:0] hi_pair;

  generate
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      assign ch[n] = i[n*WIDTH +: WIDTH];
    end
  endgenerate

  // First level: s[0] picks within {ch0,ch1} and {ch2,ch3}.
  mux2_1 #(.WIDTH(WIDTH)) u_mux_lo (
    .a   (ch[0]),
    .b   (ch[1]),
    .sel (s[0]),
    .y   (lo_pair)
  );

  mux2_1 #(.WIDTH(WIDTH)) u_mux_hi (
    .a   (ch[2]),
    .b   (ch[3]),
    .sel (s[0]),
    .y   (hi_pair)
  );

  // Second level: s[1] picks between the two pairs.
  mux2_1 #(.WIDTH(WIDTH)) u_mux_out (
    .a   (lo_pair),
    .b   (hi_pair),
    .sel (s[1]),
    .y   (y)
  );

  assign sel_oh = sel_decode(s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiplexer4_1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_multiplexer4_1
// Purpose : Directed self-checking bench for multiplexer4_1, with a
//           WIDTH=1 instance and a WIDTH=8 instance sharing clk/rst_n/s.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_multiplexer4_1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i1;
  logic [31:0] i8;
  logic [1:0]  s;
  logic        y1;
  logic        y1_q;
  logic [3:0]  oh1;
  logic [7:0]  y8;
  logic [7:0]  y8_q;
  logic [3:0]  oh8;

  int checks = 0;
  int errors = 0;

  multiplexer4_1 #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i      (i1),
    .s      (s),
    .y      (y1),
    .y_q    (y1_q),
    .sel_oh (oh1)
  );

  multiplexer4_1 #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i      (i8),
    .s      (s),
    .y      (y8),
    .y_q    (y8_q),
    .sel_oh (oh8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] walk;
  logic [3:0] iso_vec [3];
  logic       iso_exp [3];
  logic [7:0] w8_exp  [4];

  initial begin
    iso_vec[0] = 4'b1101; iso_exp[0] = 1'b0;
    iso_vec[1] = 4'b0000; iso_exp[1] = 1'b0;
    iso_vec[2] = 4'b0010; iso_exp[2] = 1'b1;
    w8_exp[0] = 8'hAA; w8_exp[1] = 8'hBB; w8_exp[2] = 8'hCC; w8_exp[3] = 8'hDD;

    // Reset behaviour.
    rst_n = 1'b0;
    i1    = 4'b1111;
    i8    = 32'h0;
    s     = 2'b10;
    #1;
    check_eq("rst_y",    {31'd0, y1},   32'd1);
    check_eq("rst_yq",   {31'd0, y1_q}, 32'd0);
    check_eq("rst_oh",   {28'd0, oh1},  32'h4);
    check_eq("rst_yq8",  {24'd0, y8_q}, 32'd0);
    tick();
    check_eq("rst_yq_clk", {31'd0, y1_q}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rel_yq",   {31'd0, y1_q}, 32'd1);

    // Walking one across all selects.
    for (int k = 0; k < 4; k++) begin
      for (int sv = 0; sv < 4; sv++) begin
        walk = 4'b0001 << k;
        i1   = walk;
        s    = sv[1:0];
        #1;
        check_eq($sformatf("walk_y_k%0d_s%0d", k, sv), {31'd0, y1},
                 (sv == k) ? 32'd1 : 32'd0);
        check_eq($sformatf("walk_oh_s%0d", sv), {28'd0, oh1},
                 32'd1 << sv);
        tick();
        check_eq($sformatf("walk_yq_k%0d_s%0d", k, sv), {31'd0, y1_q},
                 (sv == k) ? 32'd1 : 32'd0);
      end
    end

    // Isolation: only bit 1 may matter with s=01.
    s = 2'b01;
    for (int n = 0; n < 3; n++) begin
      i1 = iso_vec[n];
      #1;
      check_eq($sformatf("iso_y%0d", n), {31'd0, y1}, {31'd0, iso_exp[n]});
      tick();
      check_eq($sformatf("iso_yq%0d", n), {31'd0, y1_q}, {31'd0, iso_exp[n]});
    end
    // Toggle unselected channels with bit 1 held high.
    i1 = 4'b0010;
    for (int n = 0; n < 8; n++) begin
      i1 = {n[2], n[1], 1'b1, n[0]};
      #1;
      check_eq($sformatf("iso_hold_y%0d", n), {31'd0, y1}, 32'd1);
    end
    tick();
    check_eq("iso_hold_yq", {31'd0, y1_q}, 32'd1);

    // Asynchronous reset between edges.
    i1 = 4'b1000;
    s  = 2'b11;
    tick();
    check_eq("mid_yq_pre", {31'd0, y1_q}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_yq_async", {31'd0, y1_q}, 32'd0);
    check_eq("mid_y",        {31'd0, y1},   32'd1);
    check_eq("mid_oh",       {28'd0, oh1},  32'h8);
    tick();
    check_eq("mid_yq_held", {31'd0, y1_q}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("mid_yq_rel", {31'd0, y1_q}, 32'd1);

    // WIDTH=8 channel selection.
    i8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int sv = 0; sv < 4; sv++) begin
      s = sv[1:0];
      #1;
      check_eq($sformatf("w8_y_s%0d", sv), {24'd0, y8}, {24'd0, w8_exp[sv]});
      check_eq($sformatf("w8_oh_s%0d", sv), {28'd0, oh8}, 32'd1 << sv);
      tick();
      check_eq($sformatf("w8_yq_s%0d", sv), {24'd0, y8_q}, {24'd0, w8_exp[sv]});
    end

    // Exhaustive WIDTH=1, with simultaneous i and s changes.
    for (int iv = 0; iv < 16; iv++) begin
      for (int sv = 0; sv < 4; sv++) begin
        walk = iv[3:0];
        i1   = walk;
        s    = sv[1:0];
        #1;
        check_eq($sformatf("ex_y_i%0d_s%0d", iv, sv), {31'd0, y1},
                 {31'd0, walk[sv]});
        check_eq($sformatf("ex_oh_s%0d", sv), {28'd0, oh1}, 32'd1 << sv);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
